clk_div_prog: RTL and testbench

Runtime-programmable integer clock divider. It replaces fixed compile-time dividers in the MCU clock tree: peripheral clocks such as the UART baud clock and timer prescalers. It produces a 50%-duty output for both even and odd divisors, or a single-cycle pulse output. Divisor and mode changes are applied only at period boundaries, so the output never glitches. It also provides a clk_in-domain tick for clock-enable style use.

---
 rtl/clk_div_prog.sv | 140 ++++++++++++++
 tb/tb_clk_div_prog.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/clk_div_prog.sv
// Runtime-programmable integer clock divider with glitch-free
// period-boundary updates, 50% duty (even/odd N) or pulse output.
module clk_div_prog #(
  parameter int DIV_W       = 8,
  parameter int DIV_DEFAULT = 2
) (
  input  logic             clk_in,
  input  logic             rst,
  input  logic             en,
  input  logic [DIV_W-1:0] div_val,
  input  logic             mode,
  input  logic             load,
  output logic             clk_out,
  output logic             tick,
  output logic [DIV_W-1:0] div_act,
  output logic             running
);

  typedef enum logic {
    S_IDLE = 1'b0,
    S_RUN  = 1'b1
  } state_t;

  localparam logic [DIV_W-1:0] DIV_RST = DIV_W'(DIV_DEFAULT);
  localparam logic [DIV_W-1:0] DIV_MIN = DIV_W'(2);
  localparam logic [DIV_W-1:0] ONE     = DIV_W'(1);

  state_t           r_state;
  state_t           w_state_nx;
  logic [DIV_W-1:0] r_cnt;
  logic [DIV_W-1:0] w_cnt_nx;
  logic [DIV_W-1:0] r_div_act;
  logic [DIV_W-1:0] w_div_nx;
  logic             r_mode_act;
  logic             w_mode_nx;
  logic [DIV_W-1:0] r_pend_div;
  logic             r_pend_mode;
  logic             r_pend_flag;
  logic             w_pend_flag_nx;
  logic [DIV_W-1:0] w_ld_div;
  logic [DIV_W-1:0] w_pend_div;
  logic             w_pend_mode;
  logic             w_pend_v;
  logic             w_wrap;
  logic             w_bound;
  logic             r_p;
  logic             w_p_nx;
  logic             r_q;
  logic             r_tick;
  logic             w_tick_nx;

  // Divisors below 2 cannot form a period; clamp on capture.
  assign w_ld_div    = (div_val < DIV_MIN) ? DIV_MIN : div_val;
  // A load on the boundary edge itself takes effect immediately.
  assign w_pend_v    = load | r_pend_flag;
  assign w_pend_div  = load ? w_ld_div : r_pend_div;
  assign w_pend_mode = load ? mode : r_pend_mode;

  // Next state: counting, boundary application, start/stop, outputs.
  always_comb begin
    w_state_nx     = r_state;
    w_cnt_nx       = '0;
    w_div_nx       = r_div_act;
    w_mode_nx      = r_mode_act;
    w_pend_flag_nx = r_pend_flag;
    w_p_nx         = 1'b0;
    w_tick_nx      = 1'b0;
    w_wrap         = 1'b0;
    w_bound        = 1'b0;
    unique case (r_state)
      S_IDLE: w_bound = 1'b1;
      S_RUN: begin
        w_wrap  = (r_cnt == (r_div_act - ONE));
        w_bound = w_wrap;
      end
      default: w_bound = 1'b1;
    endcase
    if (w_bound) begin
      if (w_pend_v) begin
        w_div_nx  = w_pend_div;
        w_mode_nx = w_pend_mode;
      end
      w_pend_flag_nx = 1'b0;
      w_state_nx     = en ? S_RUN : S_IDLE;
    end else begin
      w_cnt_nx = r_cnt + ONE;
      if (load) begin
        w_pend_flag_nx = 1'b1;
      end
    end
    if (w_state_nx == S_RUN) begin
      if (w_mode_nx) begin
        w_p_nx = (w_cnt_nx == '0);
      end else begin
        w_p_nx = (w_cnt_nx < (w_div_nx >> 1));
      end
      w_tick_nx = (w_cnt_nx == (w_div_nx - ONE));
    end
  end

  // Posedge state and registered outputs.
  always_ff @(posedge clk_in or posedge rst) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_cnt       <= '0;
      r_div_act   <= DIV_RST;
      r_mode_act  <= 1'b0;
      r_pend_div  <= DIV_RST;
      r_pend_mode <= 1'b0;
      r_pend_flag <= 1'b0;
      r_p         <= 1'b0;
      r_tick      <= 1'b0;
    end else begin
      r_state     <= w_state_nx;
      r_cnt       <= w_cnt_nx;
      r_div_act   <= w_div_nx;
      r_mode_act  <= w_mode_nx;
      r_pend_div  <= w_pend_div;
      r_pend_mode <= w_pend_mode;
      r_pend_flag <= w_pend_flag_nx;
      r_p         <= w_p_nx;
      r_tick      <= w_tick_nx;
    end
  end

  // Half-cycle stretch of the high phase for odd divisors in 50% mode.
  always_ff @(negedge clk_in or posedge rst) begin
    if (rst) begin
      r_q <= 1'b0;
    end else begin
      r_q <= r_p & ~r_mode_act & r_div_act[0];
    end
  end

  assign clk_out = r_p | r_q;
  assign tick    = r_tick;
  assign div_act = r_div_act;
  assign running = (r_state == S_RUN);

endmodule

// File: tb/tb_clk_div_prog.sv
// Scoreboard bench for clk_div_prog: a period-level waveform model
// feeds per-cycle expectations to an edge-sampling monitor.
module tb_clk_div_prog;

  logic       clk_in;
  logic       rst;
  logic       en;
  logic [7:0] div_val;
  logic       mode;
  logic       load;
  logic       clk_out;
  logic       tick;
  logic [7:0] div_act;
  logic       running;

  clk_div_prog #(.DIV_W(8), .DIV_DEFAULT(2)) dut (
    .clk_in  (clk_in),
    .rst     (rst),
    .en      (en),
    .div_val (div_val),
    .mode    (mode),
    .load    (load),
    .clk_out (clk_out),
    .tick    (tick),
    .div_act (div_act),
    .running (running)
  );

  initial clk_in = 1'b0;
  always #5 clk_in = ~clk_in;

  typedef struct packed {
    logic       h0;
    logic       h1;
    logic       tk;
    logic       run;
    logic [7:0] div;
  } exp_t;

  exp_t exp_q[$];
  int   total = 0;
  int   bad   = 0;
  logic have_h1 = 1'b0;
  logic exp_h1;

  // Reference model: whole-period waveform as half-cycle levels.
  int   m_run;
  int   m_n;
  int   m_mode;
  int   m_pf;
  int   m_pn;
  int   m_pm;
  logic wave[$];

  task automatic chk(string nm, int act, int expv);
    total++;
    if (act != expv) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, expv, $time);
    end
  endtask

  task automatic model_reset();
    m_run  = 0;
    m_n    = 2;
    m_mode = 0;
    m_pf   = 0;
    m_pn   = 2;
    m_pm   = 0;
    wave.delete();
  endtask

  task automatic model_step(logic e, logic ld, int dv, logic md);
    exp_t x;
    int   nld;
    nld = (dv < 2) ? 2 : dv;
    if (m_run == 0 || wave.size() == 0) begin
      if (ld) begin
        m_n    = nld;
        m_mode = md;
        m_pf   = 0;
      end else if (m_pf != 0) begin
        m_n    = m_pn;
        m_mode = m_pm;
        m_pf   = 0;
      end
      m_run = e ? 1 : 0;
      wave.delete();
      if (e) begin
        for (int i = 0; i < 2 * m_n; i++) begin
          if (m_mode != 0) wave.push_back(i < 2);
          else wave.push_back(i < m_n);
        end
      end
    end else if (ld) begin
      m_pf = 1;
      m_pn = nld;
      m_pm = md;
    end
    if (m_run != 0) begin
      x.h0 = wave.pop_front();
      x.h1 = wave.pop_front();
      x.tk = (wave.size() == 0);
    end else begin
      x.h0 = 1'b0;
      x.h1 = 1'b0;
      x.tk = 1'b0;
    end
    x.run = (m_run != 0);
    x.div = 8'(m_n);
    exp_q.push_back(x);
  endtask

  task automatic drive(logic e, logic ld, int dv, logic md);
    en      = e;
    load    = ld;
    div_val = 8'(dv);
    mode    = md;
    model_step(e, ld, dv, md);
  endtask

  task automatic cyc(logic e, logic ld, int dv, logic md);
    @(negedge clk_in);
    #1;
    drive(e, ld, dv, md);
  endtask

  task automatic run_n(int n);
    for (int i = 0; i < n; i++) cyc(1'b1, 1'b0, 0, 1'b0);
  endtask

  // Monitor: first half sampled after posedge, second after negedge.
  initial begin
    exp_t x;
    forever begin
      @(posedge clk_in);
      #2;
      if (exp_q.size() > 0) begin
        x = exp_q.pop_front();
        chk("clk_out_hi_half", int'(clk_out), int'(x.h0));
        chk("tick", int'(tick), int'(x.tk));
        chk("running", int'(running), int'(x.run));
        chk("div_act", int'(div_act), int'(x.div));
        exp_h1  = x.h1;
        have_h1 = 1'b1;
      end
      @(negedge clk_in);
      #2;
      if (have_h1) begin
        chk("clk_out_lo_half", int'(clk_out), int'(exp_h1));
        have_h1 = 1'b0;
      end
    end
  end

  initial begin
    logic found;
    logic ren;
    int   dv;
    rst     = 1'b1;
    en      = 1'b0;
    load    = 1'b0;
    div_val = 8'd0;
    mode    = 1'b0;
    model_reset();
    repeat (2) @(posedge clk_in);
    #3;
    chk("rst_clk_out", int'(clk_out), 0);
    chk("rst_tick", int'(tick), 0);
    chk("rst_running", int'(running), 0);
    chk("rst_div_act", int'(div_act), 2);

    @(negedge clk_in);
    #1;
    rst = 1'b0;
    drive(1'b1, 1'b0, 0, 1'b0);
    run_n(8);
    cyc(1'b1, 1'b1, 4, 1'b0);
    run_n(12);
    cyc(1'b1, 1'b1, 5, 1'b0);
    run_n(16);
    cyc(1'b1, 1'b1, 6, 1'b1);
    run_n(20);
    cyc(1'b1, 1'b1, 7, 1'b0);
    run_n(9);
    for (int i = 0; i < 4; i++) cyc(1'b0, 1'b0, 0, 1'b0);
    run_n(10);
    for (int i = 0; i < 3; i++) cyc(1'b0, 1'b0, 0, 1'b0);
    run_n(12);
    for (int i = 0; i < 12; i++) cyc(1'b0, 1'b0, 0, 1'b0);
    cyc(1'b0, 1'b1, 0, 1'b0);
    run_n(6);
    cyc(1'b1, 1'b1, 3, 1'b0);
    cyc(1'b1, 1'b1, 5, 1'b0);
    run_n(4);

    found = 1'b0;
    for (int i = 0; i < 40 && !found; i++) begin
      cyc(1'b1, 1'b0, 0, 1'b0);
      @(posedge clk_in);
      #3;
      if (clk_out === 1'b1 && div_act == 8'd5) found = 1'b1;
    end
    chk("wait_n5_high", int'(found), 1);
    rst = 1'b1;
    exp_q.delete();
    have_h1 = 1'b0;
    #1;
    chk("mid_rst_clk_out", int'(clk_out), 0);
    chk("mid_rst_div_act", int'(div_act), 2);
    chk("mid_rst_running", int'(running), 0);
    chk("mid_rst_tick", int'(tick), 0);
    model_reset();
    @(negedge clk_in);
    #1;
    rst = 1'b0;
    drive(1'b1, 1'b0, 0, 1'b0);
    run_n(6);

    ren = 1'b1;
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 39) == 0) ren = ~ren;
      if ($urandom_range(0, 9) == 0) dv = $urandom_range(0, 60);
      else dv = $urandom_range(0, 12);
      cyc(ren, 1'($urandom_range(0, 9) == 0), dv, 1'($urandom_range(0, 1)));
    end
    cyc(1'b0, 1'b0, 0, 1'b0);

    repeat (2) @(negedge clk_in);
    #4;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
